arbiter_rr4: RTL and testbench



---
 rtl/arbiter_rr4.sv | 96 +++++++++
 tb/tb_arbiter_rr4.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr4.sv
// Four-requester round-robin arbiter driving a 2-to-4 decoder (EN, A1, A0).
// Grants are held for at most HOLD_MAX cycles and are always separated by one idle cycle.
module arbiter_rr4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] REQ,
    output logic       EN,
    output logic       A1,
    output logic       A0,
    output logic       TO
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_CNT = 8'(HOLD_MAX);

    state_t     state;
    state_t     next_state;
    logic [1:0] ptr;
    logic [1:0] idx;
    logic [1:0] sel;
    logic [1:0] offset;
    logic [7:0] cnt;
    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic       hold_done;
    logic       timeout;
    logic       to_q;

    // Rotate the request vector so bit 0 is the requester at ptr; first set bit wins.
    assign req_dbl   = {REQ, REQ} >> ptr;
    assign req_rot   = req_dbl[3:0];
    assign hold_done = (cnt == HOLD_CNT);

    always_comb begin
        offset = 2'd3;
        if (req_rot[0])
            offset = 2'd0;
        else if (req_rot[1])
            offset = 2'd1;
        else if (req_rot[2])
            offset = 2'd2;
        sel = ptr + offset;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            ptr   <= 2'd0;
            idx   <= 2'd0;
            cnt   <= 8'd0;
            to_q  <= 1'b0;
        end else begin
            state <= next_state;
            to_q  <= timeout;
            if (state == IDLE && |REQ) begin
                idx <= sel;
                ptr <= sel + 2'd1;
                cnt <= 8'd1;
            end else if (state == GRANT && REQ[idx] && !hold_done) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // A request drop takes priority over the hold limit, so timeout needs REQ[idx] still high.
    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (|REQ)
                    next_state = GRANT;
            end
            GRANT: begin
                if (!REQ[idx]) begin
                    next_state = IDLE;
                end else if (hold_done) begin
                    next_state = IDLE;
                    timeout    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        EN = (state == GRANT);
        A1 = idx[1];
        A0 = idx[0];
        TO = to_q;
    end

endmodule

// File: tb/tb_arbiter_rr4.sv
// Directed self-checking bench for arbiter_rr4; three instances cover HOLD_MAX = 8, 2 and 4.
// Observed values are packed as {EN, A1, A0, TO}.
module tb_arbiter_rr4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b, req_c;
    logic       en_a, a1_a, a0_a, to_a;
    logic       en_b, a1_b, a0_b, to_b;
    logic       en_c, a1_c, a0_c, to_c;
    int         compared;
    int         mismatched;

    arbiter_rr4 #(.HOLD_MAX(8)) dut_a (
        .CLK(clk), .RST_N(rst_n), .REQ(req_a),
        .EN(en_a), .A1(a1_a), .A0(a0_a), .TO(to_a)
    );

    arbiter_rr4 #(.HOLD_MAX(2)) dut_b (
        .CLK(clk), .RST_N(rst_n), .REQ(req_b),
        .EN(en_b), .A1(a1_b), .A0(a0_b), .TO(to_b)
    );

    arbiter_rr4 #(.HOLD_MAX(4)) dut_c (
        .CLK(clk), .RST_N(rst_n), .REQ(req_c),
        .EN(en_c), .A1(a1_c), .A0(a0_c), .TO(to_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got {EN,A1,A0,TO}=%b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkA(input string tag, input logic [3:0] expected);
        checkOutput(tag, {en_a, a1_a, a0_a, to_a}, expected);
    endtask

    task automatic checkB(input string tag, input logic [3:0] expected);
        checkOutput(tag, {en_b, a1_b, a0_b, to_b}, expected);
    endtask

    task automatic checkC(input string tag, input logic [3:0] expected);
        checkOutput(tag, {en_c, a1_c, a0_c, to_c}, expected);
    endtask

    initial begin
        logic [3:0] exp_grant;
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        req_a      = 4'b1111;
        req_b      = 4'b0000;
        req_c      = 4'b0000;

        // Reset holds everything low despite requests, then index 0 wins first.
        step();
        step();
        checkA("reset_hold", 4'b0_00_0);
        rst_n = 1'b1;
        step();
        checkA("first_grant_idx0", 4'b1_00_0);
        req_a = 4'b0000;
        step();
        checkA("release_idx0", 4'b0_00_0);

        // Single request on channel 2 for three cycles, HOLD_MAX 8.
        req_a = 4'b0100;
        step();
        checkA("single_c1", 4'b1_10_0);
        step();
        checkA("single_c2", 4'b1_10_0);
        step();
        checkA("single_c3", 4'b1_10_0);
        req_a = 4'b0000;
        step();
        checkA("single_release", 4'b0_10_0);
        req_a = 4'b1111;
        step();
        checkA("single_ptr3", 4'b1_11_0);
        req_a = 4'b0000;
        step();
        checkA("single_ptr3_release", 4'b0_11_0);

        // Fairness with all four requesting, HOLD_MAX 2: grant order 0,1,2,3,0.
        req_b = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_grant = {1'b1, 2'(g % 4), 1'b0};
            step();
            checkB($sformatf("rr%0d_cyc1", g), exp_grant);
            step();
            checkB($sformatf("rr%0d_cyc2", g), exp_grant);
            step();
            checkB($sformatf("rr%0d_timeout", g), {1'b0, exp_grant[2:1], 1'b1});
        end
        req_b = 4'b0000;
        step();
        checkB("rr_quiet", 4'b0_00_0);

        // Wrap-around: grant 2 moves ptr to 3, then 0011 gives 0 then 1.
        req_b = 4'b0100;
        step();
        checkB("wrap_grant2", 4'b1_10_0);
        req_b = 4'b0000;
        step();
        checkB("wrap_release2", 4'b0_10_0);
        req_b = 4'b0011;
        step();
        checkB("wrap_grant0", 4'b1_00_0);
        step();
        checkB("wrap_grant0_c2", 4'b1_00_0);
        step();
        checkB("wrap_timeout0", 4'b0_00_1);
        step();
        checkB("wrap_grant1", 4'b1_01_0);
        req_b = 4'b0000;
        step();
        checkB("wrap_release1", 4'b0_01_0);

        // HOLD_MAX 4: drop on the same edge as CNT==4 is a normal release.
        req_c = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            step();
            checkC($sformatf("drop_c%0d", k), 4'b1_01_0);
        end
        req_c = 4'b0000;
        step();
        checkC("drop_no_timeout", 4'b0_01_0);
        step();
        checkC("drop_to_stays_low", 4'b0_01_0);

        // Same channel held past the limit: forced release, then regrant after one idle cycle.
        req_c = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            step();
            checkC($sformatf("hold_c%0d", k), 4'b1_01_0);
        end
        step();
        checkC("hold_timeout", 4'b0_01_1);
        step();
        checkC("hold_regrant", 4'b1_01_0);
        req_c = 4'b0000;
        step();
        checkC("hold_release", 4'b0_01_0);

        // Reset in the second grant cycle of index 2 drops EN without a clock edge.
        req_a = 4'b0100;
        step();
        checkA("mid_grant_c1", 4'b1_10_0);
        step();
        checkA("mid_grant_c2", 4'b1_10_0);
        rst_n = 1'b0;
        #1;
        checkA("async_reset", 4'b0_00_0);
        step();
        rst_n = 1'b1;
        step();
        checkA("post_reset_grant2", 4'b1_10_0);
        req_a = 4'b0000;
        step();
        checkA("post_reset_release", 4'b0_10_0);
        req_a = 4'b1111;
        step();
        checkA("post_reset_ptr3", 4'b1_11_0);
        req_a = 4'b0000;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
